// File: rtl/tinyalu_checker_if.sv
// tinyalu_checker_if: TinyALU pin-level bus (start/op/A/B/done/result); master drives, slave observes
interface tinyalu_checker_if #(
    parameter int DATA_W = 8
);
    logic                  start;
    logic [2:0]            op;
    logic [DATA_W-1:0]     A;
    logic [DATA_W-1:0]     B;
    logic                  done;
    logic [2*DATA_W-1:0]   result;
    modport master (output start, op, A, B, done, result);
    modport slave  (input  start, op, A, B, done, result);
endinterface

// File: rtl/tinyalu_checker.sv
// tinyalu_checker: predicts TinyALU results per issued command, queues them and scores each done (optional TINYALU_CHECKER_TIMEOUT_EN adds head-age timeout)
// Ports: clk, reset_n (async active-low), bus (slave view of start/op/A/B/done/result),
//        pass_cnt/fail_cnt (saturating), err (sticky), err_pulse, exp_first/act_first/op_first, level
module tinyalu_checker #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    tinyalu_checker_if.slave      bus,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      fail_cnt,
    output logic                  err,
    output logic                  err_pulse,
    output logic [2*DATA_W-1:0]   exp_first,
    output logic [2*DATA_W-1:0]   act_first,
    output logic [2:0]            op_first,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int RW = 2 * DATA_W;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("tinyalu_checker: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    logic            start_q;
    logic [PW-1:0]   wr_q, rd_q;
    logic [PW:0]     level_q, level_d;
    logic [2:0]      op_mem_q [DEPTH];
    logic [RW-1:0]   pred_mem_q [DEPTH];
    logic [CNT_W-1:0] pass_q, fail_q;
    logic            err_q, pulse_q, first_q;
    logic [RW-1:0]   exp_first_q, act_first_q;
    logic [2:0]      op_first_q;

    logic            issue, flush, push_req, push, pop, done_pop, spurious, timeout_pop;
    logic            empty, full, match, pass_ev, bad_ev, fail_ev, overflow, err_ev;
    logic [RW-1:0]   pred, head_pred, act_val;
    logic [2:0]      head_op;

    assign issue     = bus.start & ~start_q;
    assign flush     = issue & (bus.op == 3'b111);
    assign push_req  = issue & (bus.op inside {[3'b001:3'b100]});
    assign empty     = level_q == '0;
    assign full      = level_q == (PW+1)'(DEPTH);
    assign head_pred = pred_mem_q[rd_q];
    assign head_op   = op_mem_q[rd_q];

    always_comb begin
        pred = bus.op == 3'b001 ? RW'(bus.A) + RW'(bus.B) :
               bus.op == 3'b010 ? RW'(bus.A & bus.B) :
               bus.op == 3'b011 ? RW'(bus.A ^ bus.B) :
                                  RW'(bus.A) * RW'(bus.B);
    end

    // A done racing a flush has nothing left to match against
    assign done_pop = bus.done & ~empty & ~flush;
    assign spurious = bus.done & (empty | flush);

`ifdef TINYALU_CHECKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1) + 1;
    logic [TW-1:0] now_q;
    logic [TW-1:0] ts_mem_q [DEPTH];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) now_q <= '0;
        else          now_q <= now_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (push) ts_mem_q[wr_q] <= now_q;
    end
    // The extra stamp bit keeps the modular age unambiguous beyond TIMEOUT; a real done wins over a timeout
    assign timeout_pop = ~empty & ~bus.done & ~flush & ((now_q - ts_mem_q[rd_q]) > TW'(TIMEOUT));
`else
    assign timeout_pop = 1'b0;
`endif

    assign pop      = done_pop | timeout_pop;
    assign match    = head_pred == bus.result;
    assign pass_ev  = done_pop & match;
    assign bad_ev   = (done_pop & ~match) | timeout_pop;
    assign fail_ev  = bad_ev | spurious;
    assign overflow = push_req & full & ~pop;
    assign push     = push_req & ~overflow;
    assign err_ev   = fail_ev | overflow;
    assign act_val  = timeout_pop ? '0 : bus.result;
    assign level_d  = level_q + (PW+1)'(push) - (PW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem_q[wr_q]   <= bus.op;
            pred_mem_q[wr_q] <= pred;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_q     <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            level_q     <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            err_q       <= 1'b0;
            pulse_q     <= 1'b0;
            first_q     <= 1'b0;
            exp_first_q <= '0;
            act_first_q <= '0;
            op_first_q  <= '0;
        end else begin
            start_q <= bus.start;
            if (flush) begin
                wr_q    <= '0;
                rd_q    <= '0;
                level_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + 1'b1;
                if (pop)  rd_q <= rd_q + 1'b1;
                level_q <= level_d;
            end
            if (pass_ev && !(&pass_q)) pass_q <= pass_q + 1'b1;
            if (fail_ev && !(&fail_q)) fail_q <= fail_q + 1'b1;
            err_q   <= err_q | err_ev;
            pulse_q <= err_ev;
            if (bad_ev && !first_q) begin
                first_q     <= 1'b1;
                exp_first_q <= head_pred;
                act_first_q <= act_val;
                op_first_q  <= head_op;
            end
        end
    end

    assign pass_cnt  = pass_q;
    assign fail_cnt  = fail_q;
    assign err       = err_q;
    assign err_pulse = pulse_q;
    assign exp_first = exp_first_q;
    assign act_first = act_first_q;
    assign op_first  = op_first_q;
    assign level     = level_q;
endmodule

// File: tb/tb_tinyalu_checker.sv
// tb_tinyalu_checker: table-driven, scoreboarded bench for tinyalu_checker
module tb_tinyalu_checker;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 16;
`ifdef TINYALU_CHECKER_TIMEOUT_EN
    localparam int TO = 10;
`else
    localparam int TO = 255;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    tinyalu_checker_if #(.DATA_W(DW)) bus();

    logic [CW-1:0]   pass_cnt, fail_cnt;
    logic            err, err_pulse;
    logic [2*DW-1:0] exp_first, act_first;
    logic [2:0]      op_first;
    logic [$clog2(DEPTH):0] level;

    tinyalu_checker #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err), .err_pulse(err_pulse),
        .exp_first(exp_first), .act_first(act_first), .op_first(op_first), .level(level)
    );

    typedef struct { logic [2:0] op; logic [7:0] a; logic [7:0] b; logic [15:0] exp; logic [15:0] resp; } vec_t;
    typedef struct { logic [2:0] op; logic [15:0] exp; } sb_t;

    vec_t vecs[6];
    sb_t  sb[$];
    int   n_chk = 0, n_fail = 0;
    int   m_pass, m_fail;
    logic m_err, m_pulse, m_first;
    logic [15:0] m_exp_f, m_act_f;
    logic [2:0]  m_op_f;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] pred(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b001:  return 16'(a) + 16'(b);
            3'b010:  return 16'(a & b);
            3'b011:  return 16'(a ^ b);
            3'b100:  return 16'(a) * 16'(b);
            default: return 16'h0;
        endcase
    endfunction

    function automatic void model_reset();
        sb.delete();
        m_pass = 0; m_fail = 0; m_err = 0; m_pulse = 0; m_first = 0;
        m_exp_f = 0; m_act_f = 0; m_op_f = 0;
    endfunction

    function automatic void model_issue(input logic [2:0] op, input logic [15:0] exp);
        if (op >= 3'b001 && op <= 3'b100) begin
            if (sb.size() == DEPTH) begin m_err = 1; m_pulse = 1; end
            else sb.push_back('{op, exp});
        end else if (op == 3'b111) sb.delete();
    endfunction

    function automatic void model_done(input logic [15:0] res);
        sb_t e;
        if (sb.size() == 0) begin
            m_fail++; m_err = 1; m_pulse = 1;
        end else begin
            e = sb.pop_front();
            if (e.exp == res) m_pass++;
            else begin
                m_fail++; m_err = 1; m_pulse = 1;
                if (!m_first) begin m_first = 1; m_exp_f = e.exp; m_act_f = res; m_op_f = e.op; end
            end
        end
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".pass_cnt"},  pass_cnt,  m_pass);
        check({tag, ".fail_cnt"},  fail_cnt,  m_fail);
        check({tag, ".err"},       err,       m_err);
        check({tag, ".err_pulse"}, err_pulse, m_pulse);
        check({tag, ".level"},     level,     sb.size());
        check({tag, ".exp_first"}, exp_first, m_exp_f);
        check({tag, ".act_first"}, act_first, m_act_f);
        check({tag, ".op_first"},  op_first,  m_op_f);
    endtask

    // One bus cycle of stimulus, then an idle cycle so start can fall and err_pulse must clear
    task automatic step(input logic s, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input logic d, input logic [15:0] res, input string tag);
        bus.start = s; bus.op = op; bus.A = a; bus.B = b; bus.done = d; bus.result = res;
        m_pulse = 0;
        if (d) model_done(res);
        if (s) model_issue(op, exp);
        @(negedge clk);
        bus.start = 0; bus.done = 0;
        check_state(tag);
        m_pulse = 0;
        @(negedge clk);
        check({tag, ".pulse_clr"}, err_pulse, 1'b0);
    endtask

    initial begin
        int saved_pass;
        vecs[0] = '{3'b001, 8'hFF, 8'h01, 16'h0100, 16'h0100};
        vecs[1] = '{3'b100, 8'hFF, 8'hFF, 16'hFE01, 16'hFE01};
        vecs[2] = '{3'b010, 8'hF0, 8'h3C, 16'h0030, 16'h0030};
        vecs[3] = '{3'b011, 8'hF0, 8'h3C, 16'h00CC, 16'h00CC};
        vecs[4] = '{3'b001, 8'h02, 8'h03, 16'h0005, 16'h0006};
        vecs[5] = '{3'b011, 8'h0F, 8'h0F, 16'h0000, 16'h0001};

        model_reset();
        reset_n = 0;
        bus.start = 0; bus.op = 0; bus.A = 0; bus.B = 0; bus.done = 1; bus.result = 16'hFFFF;
        repeat (3) @(negedge clk);
        check_state("reset");
        bus.done = 0; bus.result = 0; reset_n = 1;
        repeat (5) @(negedge clk);
        check("post_reset.err", err, 1'b0);

        for (int i = 0; i < 6; i++) begin
            step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, 16'h0, $sformatf("vec%0d_issue", i));
            step(1'b0, 3'b000, 8'h0, 8'h0, 16'h0, 1'b1, vecs[i].resp, $sformatf("vec%0d_done", i));
            if (i == 3) begin
                check("seq.pass_cnt", pass_cnt, 4);
                check("seq.fail_cnt", fail_cnt, 0);
                check("seq.err", err, 0);
            end
            if (i == 4) begin
                check("mis.fail_cnt", fail_cnt, 1);
                check("mis.exp_first", exp_first, 16'h0005);
                check("mis.act_first", act_first, 16'h0006);
                check("mis.op_first", op_first, 3'b001);
            end
        end
        check("mis2.exp_first", exp_first, 16'h0005);
        check("mis2.act_first", act_first, 16'h0006);

        for (int k = 0; k < 5; k++)
            step(1'b1, 3'b001, 8'(k), 8'h01, pred(3'b001, 8'(k), 8'h01), 1'b0, 16'h0, $sformatf("fill%0d", k));
        check("overflow.level", level, 4);
        step(1'b1, 3'b001, 8'h10, 8'h01, pred(3'b001, 8'h10, 8'h01), 1'b1, 16'h0001, "full_pushpop");
        check("full_pushpop.level", level, 4);
        while (sb.size() > 0)
            step(1'b0, 3'b000, 8'h0, 8'h0, 16'h0, 1'b1, sb[0].exp, "drain");
        step(1'b0, 3'b000, 8'h0, 8'h0, 16'h0, 1'b1, 16'h1234, "spurious");

        for (int k = 0; k < 3; k++)
            step(1'b1, 3'b011, 8'(k), 8'hA5, pred(3'b011, 8'(k), 8'hA5), 1'b0, 16'h0, "pend");
        saved_pass = m_pass;
        step(1'b1, 3'b111, 8'h0, 8'h0, 16'h0, 1'b0, 16'h0, "rst_op");
        check("rst_op.level", level, 0);
        step(1'b0, 3'b000, 8'h0, 8'h0, 16'h0, 1'b1, 16'h00A5, "after_flush");
        check("after_flush.pass_kept", pass_cnt, saved_pass);

        step(1'b1, 3'b001, 8'h01, 8'h01, 16'h0002, 1'b0, 16'h0, "pre_reset_a");
        step(1'b1, 3'b010, 8'h01, 8'h01, 16'h0001, 1'b0, 16'h0, "pre_reset_b");
        reset_n = 0;
        model_reset();
        @(negedge clk);
        check_state("mid_reset");
        reset_n = 1;
        @(negedge clk);

        step(1'b1, 3'b100, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 16'h0, "stall_issue");
`ifdef TINYALU_CHECKER_TIMEOUT_EN
        repeat (20) @(negedge clk);
        check("timeout.err", err, 1'b1);
        check("timeout.level", level, 0);
        check("timeout.fail_cnt", fail_cnt, 1);
        check("timeout.exp_first", exp_first, 16'hFE01);
        check("timeout.act_first", act_first, 16'h0000);
        check("timeout.op_first", op_first, 3'b100);
`else
        repeat (1000) @(negedge clk);
        check("stall.err", err, 1'b0);
        check("stall.level", level, 1);
        check("stall.fail_cnt", fail_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tinyalu_checker.md
# tinyalu_checker

Synthesizable, parametrised result checker for the TinyALU datapath; sits alongside the DUT on the same pin-level signals the BFM drives. Captures each command at issue, predicts its result, queues predictions for pipelined or overlapping operations, and compares against the DUT result on every `done`. Exposes pass/fail counters and a first-mismatch record so both simulation benches and on-chip debug can read them.

## Interface
- `DATA_W`, 8, operand width; result width is `2*DATA_W`
- `DEPTH`, 4, outstanding-command queue depth (power of two, ≥2)
- `CNT_W`, 16, width of pass/fail counters (saturating)
- `TIMEOUT`, 255, max cycles from issue to `done` (used only with the macro in Configuration)

Ports:
- `clk` in 1 — clock
- `reset_n` in 1 — asynchronous active-low reset
- `start` in 1 — DUT start, held high until `done`
- `op` in 3 — 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 111 rst_op
- `A`, `B` in `DATA_W` — operands, valid with `start`
- `done` in 1 — DUT completion strobe
- `result` in `2*DATA_W` — DUT result, valid with `done`
- `pass_cnt`, `fail_cnt` out `CNT_W` — saturating counts
- `err` out 1 — sticky, set on any fail, overflow, spurious `done` or timeout
- `err_pulse` out 1 — one-cycle pulse per error event
- `exp_first`, `act_first` out `2*DATA_W` — expected/actual of first mismatch
- `op_first` out 3 — op of first mismatch
- `level` out `$clog2(DEPTH)+1` — current queue occupancy

## Operation
- Issue detect: `start & ~start_q`, with `start_q` registered. Ops 001–100 push one entry {op, predicted}; no_op and other encodings are ignored.
- Prediction, zero-extended to `2*DATA_W`:
  - add: `A+B` (`DATA_W+1` bits)
  - and: `A&B`
  - xor: `A^B`
  - mul: full `A*B`
- `done` pops the head and compares it with `result`:
  - Equal: `pass_cnt`++.
  - Unequal: `fail_cnt`++, `err`←1, `err_pulse`. The first mismatch latches `exp_first`, `act_first` and `op_first`; later mismatches do not overwrite them.
- `done` with an empty queue counts as spurious: `fail_cnt`++, `err`, `err_pulse`. Nothing is popped.
- Push while full with no simultaneous pop is an overflow: the command is dropped, `err`, `err_pulse`. Push and pop in the same cycle is always legal, including when full (level unchanged).
- rst_op issue flushes the queue on the next edge. Counters and first-mismatch registers are kept. A `done` in the same cycle as the flush is treated as spurious.
- Counters saturate at all-ones and never wrap.
- Queue pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.

## Timing
- Reset, async on `reset_n` low: every output is 0, queue empty, `start_q`=0.
- A command sampled at edge N is poppable from edge N+1. If `done` arrives at edge N for a command issued at edge N, it is spurious.
- `pass_cnt`, `fail_cnt`, `err`, `err_pulse` and the first-mismatch registers update on the edge that samples `done`, so they are visible 1 cycle after `done`.
- `err_pulse` is high for exactly 1 cycle per event. Simultaneous events (e.g. mismatch and overflow) produce one pulse, and each counter increments at most once per cycle.
- `reset_n` asserted mid-operation discards all pending entries immediately. Deassertion is synchronised externally.

## Configuration
- `TINYALU_CHECKER_TIMEOUT_EN` defined:
  - Each queue entry also stores an issue timestamp from a free-running `$clog2(TIMEOUT+1)+1`-bit counter.
  - If head age exceeds `TIMEOUT` cycles, the head is popped as a failure (`fail_cnt`++, `err`, `err_pulse`, first-mismatch latches with `act_first`=0).
- Not defined: no timestamp storage, no age counter, and a stalled DUT never produces an error.

## Test plan
- Reset: hold `reset_n`=0 and drive `done`=1 → all outputs 0 and `level`=0; after release, `err` stays 0.
- DATA_W=8, sequential ops:
  - add FF+01 → expected 0x0100
  - mul FF*FF → 0xFE01
  - and F0&3C → 0x0030
  - xor F0^3C → 0x00CC
  - Correct DUT results → `pass_cnt`=4, `fail_cnt`=0, `err`=0.
- Injected mismatch: add 02+03 answered with 0x0006 → `fail_cnt`=1, `err`=1, one-cycle `err_pulse`, `exp_first`=0x0005, `act_first`=0x0006, `op_first`=001. A second wrong answer leaves the first-mismatch record unchanged.
- Queue limits, DEPTH=4:
  - 5 issues with no `done` → overflow on the 5th, `level`=4.
  - Push and pop in the same cycle while full → `level` stays 4, no error.
  - `done` on an empty queue → spurious, `fail_cnt`++.
- rst_op with 3 pending → `level`=0 next cycle; subsequent `done` flagged spurious; `pass_cnt` preserved.
- With `TINYALU_CHECKER_TIMEOUT_EN`, TIMEOUT=10: issue mul with no `done` → error on the cycle age reaches 11, `level` drops to 0. Without the macro → no error after 1000 cycles.
